// File: rtl/arb_pkg.sv
// arb_pkg: shared state type and one-hot encode helper for the round-robin arbiter
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int ARB_N = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request bit at or after ptr, wrapping modulo N
module rr_priority_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
        off = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IDX_W'(i);
        pick_valid = |req;
        pick_idx = IDX_W'((int'(off) + int'(ptr)) % N);
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter with grant hold and forced release after MAX_HOLD cycles
module rr_arbiter_8 import arb_pkg::*; #(
    parameter int N        = 8,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int HC_W = $clog2(MAX_HOLD + 2);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, grant_idx_q, grant_idx_d, pick_idx, next_ptr;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d, timeout_q, timeout_d;
    logic             pick_valid, owner_req, hold_max, release_now;

    rr_priority_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .pick_idx  (pick_idx),
        .pick_valid(pick_valid)
    );

    assign owner_req   = req[grant_idx_q];
    assign hold_max    = (MAX_HOLD != 0) && (hold_cnt_q >= HC_W'(MAX_HOLD));
    assign release_now = !owner_req || hold_max;
    assign next_ptr    = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + 1'b1;

    // next-state: pick a new owner when idle, hold or release the current owner otherwise
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        if (state_q == IDLE) begin
            if (pick_valid) begin
                state_d       = GRANT;
                grant_d       = N'(1) << pick_idx;
                grant_idx_d   = pick_idx;
                grant_valid_d = 1'b1;
                hold_cnt_d    = HC_W'(1);
            end
        end else if (release_now) begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
            ptr_d         = next_ptr;
            timeout_d     = owner_req;
        end else begin
            hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
    end

    // state and output registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
